// File: rtl/cpu_stage_sequencer.sv
// Multicycle stage sequencer for TinyCPU: stage FSM, PC, instruction and load-data registers.
// Read ports are captured on the last cycle of a MEM_READ_LATENCY wait.
module cpu_stage_sequencer #(
   parameter logic [31:0]  RESET_PC         = 32'h0000_0000,
   parameter int unsigned  MEM_READ_LATENCY = 1,
   localparam int unsigned STAGE_WIDTH      = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   run_enable,
   input  logic [4:0]             current_instr_type,
   input  logic                   branch_taken,
   input  logic [31:0]            branch_target,
   input  logic [31:0]            read_data_0,
   input  logic [31:0]            read_data_1,
   output logic [STAGE_WIDTH-1:0] stage,
   output logic [31:0]            PC_value,
   output logic [31:0]            instruction,
   output logic [31:0]            memory_read_data,
   output logic                   register_write_enable,
   output logic                   halted,
   output logic [31:0]            instr_count
);

   localparam int unsigned CNT_W   = 4;
   localparam int unsigned INSTR_W = 5;

   localparam logic [INSTR_W-1:0] INSTR_NOP    = 5'd0;
   localparam logic [INSTR_W-1:0] INSTR_ALU    = 5'd1;
   localparam logic [INSTR_W-1:0] INSTR_LOAD   = 5'd2;
   localparam logic [INSTR_W-1:0] INSTR_STORE  = 5'd3;
   localparam logic [INSTR_W-1:0] INSTR_BRANCH = 5'd4;
   localparam logic [INSTR_W-1:0] INSTR_HALT   = 5'd5;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_READ_LATENCY - 1);

   typedef enum logic [STAGE_WIDTH-1:0] {
      STAGE_FETCH     = 3'd0,
      STAGE_DECODE    = 3'd1,
      STAGE_EXECUTE   = 3'd2,
      STAGE_MEMORY    = 3'd3,
      STAGE_WRITEBACK = 3'd4,
      STAGE_HALTED    = 3'd5
   } stage_e;

   stage_e            state_q;
   stage_e            state_d;
   logic [CNT_W-1:0]  wait_cnt;
   logic [CNT_W-1:0]  wait_cnt_d;
   logic [31:0]       pc_d;
   logic [31:0]       instruction_d;
   logic [31:0]       memory_read_data_d;
   logic [31:0]       instr_count_d;

   assign stage = state_q;

   // State and datapath registers; reset leaves any stage, including a MEMORY store, at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= STAGE_FETCH;
         wait_cnt         <= '0;
         PC_value         <= RESET_PC;
         instruction      <= '0;
         memory_read_data <= '0;
         instr_count      <= '0;
      end else begin
         state_q          <= state_d;
         wait_cnt         <= wait_cnt_d;
         PC_value         <= pc_d;
         instruction      <= instruction_d;
         memory_read_data <= memory_read_data_d;
         instr_count      <= instr_count_d;
      end
   end

   // Next-state and stage-decoded outputs.
   always_comb begin
      state_d               = state_q;
      wait_cnt_d            = wait_cnt;
      pc_d                  = PC_value;
      instruction_d         = instruction;
      memory_read_data_d    = memory_read_data;
      instr_count_d         = instr_count;
      register_write_enable = 1'b0;
      halted                = 1'b0;

      case (state_q)
         STAGE_FETCH: begin
            // run_enable only matters before the wait count has begun
            if (run_enable || (wait_cnt != '0)) begin
               if (wait_cnt == LAST_CNT) begin
                  instruction_d = read_data_0;
                  wait_cnt_d    = '0;
                  state_d       = STAGE_DECODE;
               end else begin
                  wait_cnt_d = wait_cnt + CNT_W'(1);
               end
            end
         end
         STAGE_DECODE:  state_d = STAGE_EXECUTE;
         STAGE_EXECUTE: state_d = STAGE_MEMORY;
         STAGE_MEMORY: begin
            if (current_instr_type == INSTR_LOAD) begin
               if (wait_cnt == LAST_CNT) begin
                  memory_read_data_d = read_data_1;
                  wait_cnt_d         = '0;
                  state_d            = STAGE_WRITEBACK;
               end else begin
                  wait_cnt_d = wait_cnt + CNT_W'(1);
               end
            end else begin
               state_d = STAGE_WRITEBACK;
            end
         end
         STAGE_WRITEBACK: begin
            register_write_enable = !(current_instr_type inside
                                      {INSTR_STORE, INSTR_BRANCH, INSTR_HALT, INSTR_NOP});
            instr_count_d = instr_count + 32'd1;
            if (current_instr_type == INSTR_HALT) begin
               state_d = STAGE_HALTED;
            end else begin
               pc_d    = branch_taken ? branch_target : PC_value + 32'd4;
               state_d = STAGE_FETCH;
            end
         end
         STAGE_HALTED: halted = 1'b1;
         default: begin
            state_d    = STAGE_FETCH;
            wait_cnt_d = '0;
         end
      endcase
   end

   logic unused_alu;
   assign unused_alu = (INSTR_ALU == 5'd1);

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// Bench for cpu_stage_sequencer: two instances (latency 1 and 3) checked cycle by cycle
// against an instruction-level model of stage sequence, PC, counters and captured data.
module tb_cpu_stage_sequencer;

   localparam logic [4:0] INSTR_NOP    = 5'd0;
   localparam logic [4:0] INSTR_ALU    = 5'd1;
   localparam logic [4:0] INSTR_LOAD   = 5'd2;
   localparam logic [4:0] INSTR_STORE  = 5'd3;
   localparam logic [4:0] INSTR_BRANCH = 5'd4;
   localparam logic [4:0] INSTR_HALT   = 5'd5;

   localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_H = 3'd5;
   localparam logic [31:0] RPC = 32'h0000_0100;

   logic        clk;
   logic        rst_n      [2];
   logic        run_enable [2];
   logic [4:0]  itype      [2];
   logic        taken      [2];
   logic [31:0] target     [2];
   logic [31:0] rd0        [2];
   logic [31:0] rd1        [2];
   logic [2:0]  stage      [2];
   logic [31:0] pc         [2];
   logic [31:0] instr      [2];
   logic [31:0] mrd        [2];
   logic        rwe        [2];
   logic        hlt        [2];
   logic [31:0] cnt        [2];

   logic [31:0] m_pc    [2];
   logic [31:0] m_cnt   [2];
   logic [31:0] m_instr [2];
   logic [31:0] m_mrd   [2];

   int checks = 0;
   int errors = 0;

   cpu_stage_sequencer #(.RESET_PC(RPC), .MEM_READ_LATENCY(1)) dut0 (
      .clk(clk), .rst_n(rst_n[0]), .run_enable(run_enable[0]), .current_instr_type(itype[0]),
      .branch_taken(taken[0]), .branch_target(target[0]), .read_data_0(rd0[0]),
      .read_data_1(rd1[0]), .stage(stage[0]), .PC_value(pc[0]), .instruction(instr[0]),
      .memory_read_data(mrd[0]), .register_write_enable(rwe[0]), .halted(hlt[0]),
      .instr_count(cnt[0]));

   cpu_stage_sequencer #(.RESET_PC(RPC), .MEM_READ_LATENCY(3)) dut1 (
      .clk(clk), .rst_n(rst_n[1]), .run_enable(run_enable[1]), .current_instr_type(itype[1]),
      .branch_taken(taken[1]), .branch_target(target[1]), .read_data_0(rd0[1]),
      .read_data_1(rd1[1]), .stage(stage[1]), .PC_value(pc[1]), .instruction(instr[1]),
      .memory_read_data(mrd[1]), .register_write_enable(rwe[1]), .halted(hlt[1]),
      .instr_count(cnt[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int lat_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   function automatic logic writes(input logic [4:0] t);
      return !(t == INSTR_STORE || t == INSTR_BRANCH || t == INSTR_HALT || t == INSTR_NOP);
   endfunction

   task automatic check(input string name, input int d, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d at %0t: got %h expected %h", name, d, $time, act, exp);
      end
   endtask

   task automatic model_reset(input int d);
      m_pc[d] = RPC; m_cnt[d] = '0; m_instr[d] = '0; m_mrd[d] = '0;
   endtask

   task automatic check_reset(input int d);
      check("rst_stage", d, 32'(stage[d]), 32'(S_F));
      check("rst_pc", d, pc[d], RPC);
      check("rst_instr", d, instr[d], 32'h0);
      check("rst_load_data", d, mrd[d], 32'h0);
      check("rst_count", d, cnt[d], 32'h0);
      check("rst_we", d, 32'(rwe[d]), 32'h0);
      check("rst_halted", d, 32'(hlt[d]), 32'h0);
   endtask

   // One full instruction from FETCH entry, checked every cycle; model advances afterwards.
   task automatic run_instr(input int d, input logic [4:0] t, input logic [31:0] i0,
                            input logic [31:0] i1, input logic tk, input logic [31:0] tg,
                            output logic saw_we);
      int nf, nm, total;
      logic ld;
      logic [2:0] es;
      ld = (t == INSTR_LOAD);
      nf = lat_of(d);
      nm = ld ? lat_of(d) : 1;
      total = nf + nm + 3;
      saw_we = 1'b0;
      for (int k = 0; k < total; k++) begin
         if (k < nf)                es = S_F;
         else if (k == nf)          es = S_D;
         else if (k == nf + 1)      es = S_E;
         else if (k < nf + 2 + nm)  es = S_M;
         else                       es = S_W;
         @(negedge clk);
         run_enable[d] = (k == 0) ? 1'b1 : 1'($urandom);
         itype[d]  = t;
         rd0[d]    = (k == nf - 1) ? i0 : $urandom;
         rd1[d]    = (k == nf + 1 + nm) ? i1 : $urandom;
         taken[d]  = (k == total - 1) ? tk : 1'($urandom);
         target[d] = (k == total - 1) ? tg : $urandom;
         #1;
         check("stage", d, 32'(stage[d]), 32'(es));
         check("pc_stable", d, pc[d], m_pc[d]);
         check("write_enable", d, 32'(rwe[d]), 32'((es == S_W) && writes(t)));
         check("halted", d, 32'(hlt[d]), 32'h0);
         if (rwe[d]) saw_we = 1'b1;
         if (k < nf) check("instr_hold", d, instr[d], m_instr[d]);
         else        check("instr", d, instr[d], i0);
         if (es == S_W) begin
            check("count", d, cnt[d], m_cnt[d]);
            check("load_data", d, mrd[d], ld ? i1 : m_mrd[d]);
         end
      end
      run_enable[d] = 1'b0;
      m_cnt[d]   = m_cnt[d] + 32'd1;
      m_instr[d] = i0;
      if (ld) m_mrd[d] = i1;
      if (t != INSTR_HALT) m_pc[d] = tk ? tg : m_pc[d] + 32'd4;
   endtask

   typedef struct {
      logic [4:0]  t;
      logic [31:0] i0;
      logic [31:0] i1;
      logic        tk;
      logic [31:0] tg;
      logic [31:0] exp_pc;
      logic        exp_we;
   } vec_t;

   vec_t vecs [8];

   initial begin
      logic        we;
      logic [31:0] tg;
      logic [4:0]  rtypes [5];
      rtypes = '{INSTR_NOP, INSTR_ALU, INSTR_LOAD, INSTR_STORE, INSTR_BRANCH};

      vecs[0] = '{INSTR_ALU,    32'h1111_0001, 32'h0,         1'b0, 32'h0,         32'h0000_0104, 1'b1};
      vecs[1] = '{INSTR_STORE,  32'h2222_0002, 32'h0,         1'b0, 32'h0,         32'h0000_0108, 1'b0};
      vecs[2] = '{INSTR_LOAD,   32'h3333_0003, 32'hCAFE_F00D, 1'b0, 32'h0,         32'h0000_010C, 1'b1};
      vecs[3] = '{INSTR_BRANCH, 32'h4444_0004, 32'h0,         1'b1, 32'h0000_0040, 32'h0000_0040, 1'b0};
      vecs[4] = '{INSTR_BRANCH, 32'h5555_0005, 32'h0,         1'b0, 32'h0000_0080, 32'h0000_0044, 1'b0};
      vecs[5] = '{INSTR_NOP,    32'h6666_0006, 32'h0,         1'b0, 32'h0,         32'h0000_0048, 1'b0};
      vecs[6] = '{INSTR_ALU,    32'h7777_0007, 32'h0,         1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1};
      vecs[7] = '{INSTR_ALU,    32'h8888_0008, 32'h0,         1'b0, 32'h0,         32'h0000_0000, 1'b1};

      for (int d = 0; d < 2; d++) begin
         rst_n[d] = 1'b0; run_enable[d] = 1'b0; itype[d] = INSTR_NOP; taken[d] = 1'b0;
         target[d] = '0; rd0[d] = '0; rd1[d] = '0;
         model_reset(d);
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) check_reset(d);
      @(negedge clk);
      rst_n[0] = 1'b1; rst_n[1] = 1'b1;

      // Directed table on the latency-1 instance, starting at RESET_PC
      for (int i = 0; i < 8; i++) begin
         run_instr(0, vecs[i].t, vecs[i].i0, vecs[i].i1, vecs[i].tk, vecs[i].tg, we);
         check("vec_we", 0, 32'(we), 32'(vecs[i].exp_we));
         @(posedge clk); #1;
         check("vec_pc", 0, pc[0], vecs[i].exp_pc);
         check("vec_count", 0, cnt[0], 32'(i + 1));
      end

      // HALT, then frozen for 20 cycles, then async reset back to FETCH
      run_instr(0, INSTR_HALT, 32'h9999_0009, 32'h0, 1'b1, 32'h0000_0200, we);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         itype[0] = INSTR_ALU; run_enable[0] = 1'b1; rd0[0] = $urandom;
         rd1[0] = $urandom; taken[0] = 1'b1; target[0] = $urandom;
         #1;
         check("halt_stage", 0, 32'(stage[0]), 32'(S_H));
         check("halt_flag", 0, 32'(hlt[0]), 32'h1);
         check("halt_pc", 0, pc[0], m_pc[0]);
         check("halt_count", 0, cnt[0], m_cnt[0]);
         check("halt_we", 0, 32'(rwe[0]), 32'h0);
         check("halt_instr", 0, instr[0], m_instr[0]);
      end
      #1 rst_n[0] = 1'b0;
      #1 check_reset(0);
      model_reset(0);
      @(negedge clk);
      rst_n[0] = 1'b1; run_enable[0] = 1'b0;

      // Latency-3 instance: load, store, taken branch
      run_instr(1, INSTR_LOAD, 32'h0BAD_0001, 32'hDEAD_BEEF, 1'b0, 32'h0, we);
      run_instr(1, INSTR_STORE, 32'h0BAD_0002, 32'h0, 1'b0, 32'h0, we);
      check("store_no_we", 1, 32'(we), 32'h0);
      run_instr(1, INSTR_BRANCH, 32'h0BAD_0003, 32'h0, 1'b1, 32'h0000_0040, we);

      // run_enable low at FETCH holds indefinitely
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         run_enable[1] = 1'b0; itype[1] = INSTR_LOAD; rd0[1] = $urandom; rd1[1] = $urandom;
         #1;
         check("hold_stage", 1, 32'(stage[1]), 32'(S_F));
         check("hold_pc", 1, pc[1], m_pc[1]);
         check("hold_instr", 1, instr[1], m_instr[1]);
         check("hold_count", 1, cnt[1], m_cnt[1]);
      end

      // Async reset during a load's MEMORY wait, no clock edge needed
      for (int k = 0; k < 7; k++) begin
         logic [2:0] es;
         es = (k < 3) ? S_F : (k == 3) ? S_D : (k == 4) ? S_E : S_M;
         @(negedge clk);
         run_enable[1] = 1'b1; itype[1] = INSTR_LOAD; rd0[1] = $urandom; rd1[1] = $urandom;
         #1;
         check("abort_stage", 1, 32'(stage[1]), 32'(es));
      end
      #2 rst_n[1] = 1'b0;
      #1 check_reset(1);
      model_reset(1);
      @(negedge clk);
      rst_n[1] = 1'b1; run_enable[1] = 1'b0;

      // Randomised instruction streams on both instances
      for (int i = 0; i < 40; i++) begin
         for (int d = 0; d < 2; d++) begin
            tg = $urandom;
            tg = tg & 32'hFFFF_FFFC;
            run_instr(d, rtypes[$urandom_range(0, 4)], $urandom, $urandom,
                      1'($urandom), tg, we);
         end
      end
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
         check("final_pc", d, pc[d], m_pc[d]);
         check("final_count", d, cnt[d], m_cnt[d]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
